// File: rtl/spi_master_ctrl.sv
// Command-level SPI master: expands single-byte RAM write/read requests into
// two 11-bit SPI frames and captures read data from MISO, one bit per clock.
module spi_master_ctrl #(
  parameter int RD_LAT = 2,
  parameter int GAP    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rd,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       MOSI,
  output logic       SS_n,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_WAIT_RD = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  localparam logic [3:0] RD_LAST  = 4'(RD_LAT == 0 ? 0 : RD_LAT - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  state_t      state_reg, state_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic [3:0]  wait_cnt_reg, wait_cnt_next;
  logic        frame_b_reg, frame_b_next;
  logic        rd_reg, rd_next;
  logic [7:0]  addr_reg, addr_next;
  logic [7:0]  wdata_reg, wdata_next;
  logic [6:0]  cap_sr_reg, cap_sr_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic [7:0]  rsp_rdata_reg, rsp_rdata_next;
  logic        ss_n_reg, ss_n_next;
  logic        mosi_reg, mosi_next;
  logic [10:0] word;

  // State register: every output pin comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= 4'd0;
      wait_cnt_reg  <= 4'd0;
      frame_b_reg   <= 1'b0;
      rd_reg        <= 1'b0;
      addr_reg      <= 8'h00;
      wdata_reg     <= 8'h00;
      cap_sr_reg    <= 7'h00;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 8'h00;
      ss_n_reg      <= 1'b1;
      mosi_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      frame_b_reg   <= frame_b_next;
      rd_reg        <= rd_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      cap_sr_reg    <= cap_sr_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      ss_n_reg      <= ss_n_next;
      mosi_reg      <= mosi_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    wait_cnt_next  = wait_cnt_reg;
    frame_b_next   = frame_b_reg;
    rd_next        = rd_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    cap_sr_next    = cap_sr_reg;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = rsp_rdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          state_next   = ST_SHIFT;
          bit_cnt_next = 4'd0;
          frame_b_next = 1'b0;
          rd_next      = req_rd;
          addr_next    = req_addr;
          wdata_next   = req_wdata;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_reg == 4'd10) begin
          bit_cnt_next  = 4'd0;
          wait_cnt_next = 4'd0;
          if (frame_b_reg && rd_reg)
            state_next = (RD_LAT == 0) ? ST_CAPTURE : ST_WAIT_RD;
          else
            state_next = ST_GAP;
        end else begin
          bit_cnt_next = bit_cnt_reg + 4'd1;
        end
      end
      ST_WAIT_RD: begin
        if (wait_cnt_reg == RD_LAST) begin
          state_next   = ST_CAPTURE;
          bit_cnt_next = 4'd0;
        end else begin
          wait_cnt_next = wait_cnt_reg + 4'd1;
        end
      end
      ST_CAPTURE: begin
        cap_sr_next = {cap_sr_reg[5:0], MISO};
        if (bit_cnt_reg == 4'd7) begin
          state_next     = ST_GAP;
          wait_cnt_next  = 4'd0;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = {cap_sr_reg, MISO};
        end else begin
          bit_cnt_next = bit_cnt_reg + 4'd1;
        end
      end
      ST_GAP: begin
        if (wait_cnt_reg == GAP_LAST) begin
          if (frame_b_reg) begin
            state_next = ST_IDLE;
          end else begin
            state_next   = ST_SHIFT;
            frame_b_next = 1'b1;
            bit_cnt_next = 4'd0;
          end
        end else begin
          wait_cnt_next = wait_cnt_reg + 4'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Pin values for the coming cycle are derived from the next state, so the
  // first command bit appears in the cycle right after acceptance.
  always_comb begin
    word      = {rd_next, rd_next, frame_b_next,
                 frame_b_next ? (rd_next ? 8'h00 : wdata_next) : addr_next};
    ss_n_next = !(state_next == ST_SHIFT || state_next == ST_WAIT_RD ||
                  state_next == ST_CAPTURE);
    mosi_next = 1'b0;
    if (state_next == ST_SHIFT) begin
      for (int i = 0; i < 11; i++) begin
        if (bit_cnt_next == 4'(i)) mosi_next = word[10-i];
      end
    end
  end

  assign req_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign SS_n      = ss_n_reg;
  assign MOSI      = mosi_reg;

endmodule
